// File: rtl/alu_issue_pkg.sv
// Shared constants, beat type and helpers for the ALU issue stage.
// The ALU opcode encodings and RV32I field values live here so decode and consumers agree.
package alu_issue_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [2:0] ALU_OP_ADD = 3'd0;
    localparam logic [2:0] ALU_OP_SUB = 3'd1;
    localparam logic [2:0] ALU_OP_AND = 3'd2;

    localparam logic [6:0] RV_OPC_OP    = 7'b0110011;
    localparam logic [6:0] RV_OPC_OPIMM = 7'b0010011;
    localparam logic [2:0] F3_ADD       = 3'b000;
    localparam logic [2:0] F3_AND       = 3'b111;
    localparam logic [6:0] F7_BASE      = 7'b0000000;
    localparam logic [6:0] F7_SUB       = 7'b0100000;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [XLEN-1:0]   left;
        logic [XLEN-1:0]   right;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              illegal;
    } issue_beat_t;

    localparam issue_beat_t BEAT_RESET = '{
        opcode:  ALU_OP_ADD,
        left:    32'h0000_0000,
        right:   32'h0000_0000,
        rd:      5'd0,
        we:      1'b0,
        illegal: 1'b0
    };

    function automatic logic [XLEN-1:0] sext_imm12(input logic [11:0] imm);
        return {{(XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I OP/OP-IMM decode into an ALU issue beat.
// Also produces the register-file read addresses straight from the instruction word.
module alu_issue_decode
    import alu_issue_pkg::*;
(
    input  logic [XLEN-1:0]   i_instr,
    input  logic [XLEN-1:0]   i_rs1_data,
    input  logic [XLEN-1:0]   i_rs2_data,
    output logic [REG_AW-1:0] o_rs1_addr,
    output logic [REG_AW-1:0] o_rs2_addr,
    output issue_beat_t       o_beat
);

    logic [6:0]        w_opc;
    logic [2:0]        w_f3;
    logic [6:0]        w_f7;
    logic [REG_AW-1:0] w_rd;
    logic              w_legal;
    logic [2:0]        w_op;
    logic              w_use_imm;

    assign w_opc      = i_instr[6:0];
    assign w_f3       = i_instr[14:12];
    assign w_f7       = i_instr[31:25];
    assign w_rd       = i_instr[11:7];
    assign o_rs1_addr = i_instr[19:15];
    assign o_rs2_addr = i_instr[24:20];

    // Classify the instruction and pick the ALU operation and operand source.
    always_comb begin
        w_legal   = 1'b0;
        w_op      = ALU_OP_ADD;
        w_use_imm = 1'b0;
        case (w_opc)
            RV_OPC_OP: begin
                if (w_f3 == F3_ADD && w_f7 == F7_BASE) begin
                    w_legal = 1'b1;
                    w_op    = ALU_OP_ADD;
                end else if (w_f3 == F3_ADD && w_f7 == F7_SUB) begin
                    w_legal = 1'b1;
                    w_op    = ALU_OP_SUB;
                end else if (w_f3 == F3_AND && w_f7 == F7_BASE) begin
                    w_legal = 1'b1;
                    w_op    = ALU_OP_AND;
                end else begin
                    w_legal = 1'b0;
                end
            end
            RV_OPC_OPIMM: begin
                if (w_f3 == F3_ADD) begin
                    w_legal   = 1'b1;
                    w_op      = ALU_OP_ADD;
                    w_use_imm = 1'b1;
                end else if (w_f3 == F3_AND) begin
                    w_legal   = 1'b1;
                    w_op      = ALU_OP_AND;
                    w_use_imm = 1'b1;
                end else begin
                    w_legal = 1'b0;
                end
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Assemble the beat; illegal words carry zero operands and never write back.
    always_comb begin
        o_beat    = BEAT_RESET;
        o_beat.rd = w_rd;
        if (w_legal) begin
            o_beat.opcode  = w_op;
            o_beat.left    = i_rs1_data;
            o_beat.right   = w_use_imm ? sext_imm12(i_instr[31:20]) : i_rs2_data;
            o_beat.we      = (w_rd != 5'd0);
            o_beat.illegal = 1'b0;
        end else begin
            o_beat.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decode plus a main output register and one skid entry.
// in_ready is a flop so upstream never sees a combinational path from out_ready.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_instr,
    output logic [REG_AW-1:0] rs1_addr,
    output logic [REG_AW-1:0] rs2_addr,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        alu_opcode,
    output logic [XLEN-1:0]   alu_left,
    output logic [XLEN-1:0]   alu_right,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_we,
    output logic              out_illegal
);

    issue_beat_t w_dec_beat;
    issue_beat_t r_main;
    issue_beat_t r_skid;
    logic        r_out_valid;
    logic        r_skid_full;
    logic        r_in_ready;
    logic        w_accept;
    logic        w_main_free;

    alu_issue_decode u_decode (
        .i_instr    (in_instr),
        .i_rs1_data (rs1_data),
        .i_rs2_data (rs2_data),
        .o_rs1_addr (rs1_addr),
        .o_rs2_addr (rs2_addr),
        .o_beat     (w_dec_beat)
    );

    assign w_accept    = in_valid & r_in_ready;
    assign w_main_free = ~r_out_valid | out_ready;

    // Main/skid storage: skid drains into main first, new beats land in skid only while main is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main      <= BEAT_RESET;
            r_skid      <= BEAT_RESET;
            r_out_valid <= 1'b0;
            r_skid_full <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (w_main_free) begin
            if (r_skid_full) begin
                r_main      <= r_skid;
                r_out_valid <= 1'b1;
                r_skid_full <= 1'b0;
                r_in_ready  <= 1'b1;
            end else if (w_accept) begin
                r_main      <= w_dec_beat;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid      <= w_dec_beat;
            r_skid_full <= 1'b1;
            r_in_ready  <= 1'b0;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign alu_opcode  = r_main.opcode;
    assign alu_left    = r_main.left;
    assign alu_right   = r_main.right;
    assign out_rd      = r_main.rd;
    assign out_we      = r_main.we;
    assign out_illegal = r_main.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: a driver pushes expected beats on acceptance,
// a negedge monitor pops and compares them whenever a beat is consumed.
module tb_alu_issue;
    import alu_issue_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [4:0]        rs1_addr, rs2_addr;
    logic [31:0]       rs1_data, rs2_data;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        alu_opcode;
    logic [31:0]       alu_left, alu_right;
    logic [4:0]        out_rd;
    logic              out_we, out_illegal;

    logic [31:0]       rf [0:31];
    issue_beat_t       exp_q [$];
    logic [31:0]       res_q [$];
    int                errors = 0;
    int                checks = 0;
    logic              held = 1'b0;
    issue_beat_t       prev_beat;

    always #5 clk = ~clk;

    assign rs1_data = rf[rs1_addr];
    assign rs2_data = rf[rs2_addr];

    alu_issue dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_opcode(alu_opcode), .alu_left(alu_left), .alu_right(alu_right),
        .out_rd(out_rd), .out_we(out_we), .out_illegal(out_illegal)
    );

    function automatic issue_beat_t mk(input logic [2:0] op, input logic [31:0] l,
                                       input logic [31:0] r, input logic [4:0] rd,
                                       input logic we, input logic ill);
        issue_beat_t b;
        b.opcode = op; b.left = l; b.right = r; b.rd = rd; b.we = we; b.illegal = ill;
        return b;
    endfunction

    function automatic logic [31:0] alu(input issue_beat_t b);
        case (b.opcode)
            ALU_OP_ADD: return b.left + b.right;
            ALU_OP_SUB: return b.left - b.right;
            ALU_OP_AND: return b.left & b.right;
            default:    return 32'h0;
        endcase
    endfunction

    task automatic check_beat(input string name, input issue_beat_t act, input issue_beat_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got op=%0d l=%h r=%h rd=%0d we=%b ill=%b, want op=%0d l=%h r=%h rd=%0d we=%b ill=%b",
                     name, act.opcode, act.left, act.right, act.rd, act.we, act.illegal,
                     exp.opcode, exp.left, exp.right, exp.rd, exp.we, exp.illegal);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic issue_beat_t cur_beat();
        return mk(alu_opcode, alu_left, alu_right, out_rd, out_we, out_illegal);
    endfunction

    // Monitor: compare consumed beats against the scoreboard and check hold stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check_val("hold_valid", {31'd0, out_valid}, 32'd1);
                check_beat("hold_stable", cur_beat(), prev_beat);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got rd=%0d with empty scoreboard, want no beat", out_rd);
                end else begin
                    check_beat("beat", cur_beat(), exp_q.pop_front());
                    check_val("alu_result", alu(cur_beat()), res_q.pop_front());
                end
            end
            held      = out_valid && !out_ready;
            prev_beat = cur_beat();
        end
    end

    task automatic send(input logic [31:0] instr, input issue_beat_t exp, input logic [31:0] res);
        int  n = 0;
        logic acc = 1'b0;
        in_instr = instr;
        in_valid = 1'b1;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (acc) begin
            exp_q.push_back(exp);
            res_q.push_back(res);
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: instr %h not accepted, want acceptance within 20 cycles", instr);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats outstanding, want 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_SUB   = 32'h402081B3;
    localparam logic [31:0] I_AND   = 32'h0020F233;
    localparam logic [31:0] I_ADDI  = 32'hFFF00293;
    localparam logic [31:0] I_ILL   = 32'h00000000;
    localparam logic [31:0] I_ADDX0 = 32'h00208033;
    localparam logic [31:0] I_ADDI6 = 32'h00508313;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[1] = 32'd12;
        rf[2] = 32'd10;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check_beat("reset_fields", cur_beat(), BEAT_RESET);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back directed vectors at full throughput
        send(I_ADD,   mk(ALU_OP_ADD, 32'd12, 32'd10, 5'd3, 1'b1, 1'b0), 32'd22);
        send(I_SUB,   mk(ALU_OP_SUB, 32'd12, 32'd10, 5'd3, 1'b1, 1'b0), 32'd2);
        send(I_AND,   mk(ALU_OP_AND, 32'd12, 32'd10, 5'd4, 1'b1, 1'b0), 32'd8);
        send(I_ADDI,  mk(ALU_OP_ADD, 32'd0, 32'hFFFFFFFF, 5'd5, 1'b1, 1'b0), 32'hFFFFFFFF);
        send(I_ILL,   mk(ALU_OP_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1), 32'd0);
        send(I_ADDX0, mk(ALU_OP_ADD, 32'd12, 32'd10, 5'd0, 1'b0, 1'b0), 32'd22);
        send(I_ADDI6, mk(ALU_OP_ADD, 32'd12, 32'd5, 5'd6, 1'b1, 1'b0), 32'd17);
        drain();

        // Backpressure: two beats buffered, third waits; regfile change must not leak into held beats
        out_ready = 1'b0;
        fork
            begin
                send(I_ADD, mk(ALU_OP_ADD, 32'd12, 32'd10, 5'd3, 1'b1, 1'b0), 32'd22);
                send(I_SUB, mk(ALU_OP_SUB, 32'd12, 32'd10, 5'd3, 1'b1, 1'b0), 32'd2);
                rf[1] = 32'd99;
                send(I_AND, mk(ALU_OP_AND, 32'd12, 32'd10, 5'd4, 1'b1, 1'b0), 32'd8);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                check_val("in_ready_full", {31'd0, in_ready}, 32'd0);
                check_val("out_valid_held", {31'd0, out_valid}, 32'd1);
                rf[1]     = 32'd12;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats buffered: everything is dropped
        out_ready = 1'b0;
        send(I_AND, mk(ALU_OP_AND, 32'd12, 32'd10, 5'd4, 1'b1, 1'b0), 32'd8);
        send(I_SUB, mk(ALU_OP_SUB, 32'd12, 32'd10, 5'd3, 1'b1, 1'b0), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_beat("async_rst_fields", cur_beat(), BEAT_RESET);
        exp_q.delete();
        res_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("post_rst_no_replay", {31'd0, out_valid}, 32'd0);
        send(I_ADDI6, mk(ALU_OP_ADD, 32'd12, 32'd5, 5'd6, 1'b1, 1'b0), 32'd17);
        drain();
        check_val("idle_out_valid", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
